// File: rtl/io_port_bank_pkg.sv
// Shared constants and helpers for the table-driven I/O port bank.
package common;

    localparam int IO_PORT_MAX = 16;

    function automatic logic [15:0] port_slice(
        input logic [IO_PORT_MAX*16-1:0] v,
        input int                        i
    );
        return v[16*i +: 16];
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// Z80 CPU bus view used by the port logic.
interface cpu_bus;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic [15:0] a_reg;
    logic [7:0]  d_reg;

    modport master (output ioreq, rd, wr, a_reg, d_reg);
    modport slave  (input  ioreq, rd, wr, a_reg, d_reg);
endinterface

// File: rtl/io_port_bank_match.sv
// Masked address comparator for one port, gated by its enable.
module io_port_match (
    input  logic [15:0] a,
    input  logic [15:0] addr,
    input  logic [15:0] mask,
    input  logic        en,
    output logic        hit
);
    assign hit = en && (((a ^ addr) & mask) == 16'h0000);
endmodule

// File: rtl/io_port_bank.sv
// Bank of Z80 I/O port registers with masked decode and write-lock.
// Read-back onto the data bus exists only with IO_PORT_READBACK_EN.
module io_port_bank
    import common::*;
#(
    parameter int                       NPORTS    = 4,
    parameter int                       WIDTH     = 8,
    parameter logic [NPORTS*16-1:0]     PORT_ADDR = {NPORTS{16'h00FE}},
    parameter logic [NPORTS*16-1:0]     PORT_MASK = {NPORTS{16'h0001}},
    parameter logic [NPORTS*WIDTH-1:0]  PORT_RST  = '0,
    parameter logic [NPORTS-1:0]        LOCKABLE  = '0,
    parameter int                       LOCK_PORT = 0,
    parameter int                       LOCK_BIT  = 5
) (
    input  logic                     clk28,
    input  logic                     rst_n,
    cpu_bus.slave                    bus,
    input  logic [NPORTS-1:0]        port_en,
    input  logic                     unlock,
    output logic [NPORTS*WIDTH-1:0]  q,
    output logic [NPORTS-1:0]        wr_stb,
    output logic                     locked,
    output logic [7:0]               d_out,
    output logic                     d_out_active
);
    localparam int AW = IO_PORT_MAX*16;
    localparam logic [AW-1:0] ADDR_EXT = AW'(PORT_ADDR);
    localparam logic [AW-1:0] MASK_EXT = AW'(PORT_MASK);

    logic [NPORTS-1:0] hit;
    logic [NPORTS-1:0] load;
    logic              io_wr;
    logic              io_wr_q;
    logic              commit;
    logic              set_lock;

    for (genvar g = 0; g < NPORTS; g++) begin : g_match
        localparam logic [15:0] A_I = port_slice(ADDR_EXT, g);
        localparam logic [15:0] M_I = port_slice(MASK_EXT, g);
        io_port_match u_match (
            .a    (bus.a_reg),
            .addr (A_I),
            .mask (M_I),
            .en   (port_en[g]),
            .hit  (hit[g])
        );
    end

    assign io_wr  = bus.ioreq && bus.wr;
    assign commit = io_wr && !io_wr_q;

    always_comb begin
        load = '0;
        for (int i = 0; i < NPORTS; i++) begin
            load[i] = commit && hit[i]
                   && !(LOCKABLE[i] && locked && !unlock);
        end
    end

    assign set_lock = load[LOCK_PORT] && bus.d_reg[LOCK_BIT];

    // io_wr_q resets high so a write already in flight never commits
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            io_wr_q <= 1'b1;
            q       <= PORT_RST;
            wr_stb  <= '0;
            locked  <= 1'b0;
        end else begin
            io_wr_q <= io_wr;
            wr_stb  <= load;
            if (set_lock) begin
                locked <= 1'b1;
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (load[i]) begin
                    q[WIDTH*i +: WIDTH] <= bus.d_reg[WIDTH-1:0];
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.rd, bus.d_reg};

`ifdef IO_PORT_READBACK_EN
    logic       rd_hit;
    logic [7:0] rd_data;

    assign rd_hit = bus.ioreq && bus.rd && !bus.wr && (|hit);

    // descending scan leaves the lowest-index hit in rd_data
    always_comb begin
        rd_data = 8'hFF;
        for (int i = NPORTS-1; i >= 0; i--) begin
            if (hit[i]) begin
                rd_data[WIDTH-1:0] = q[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            d_out        <= 8'hFF;
            d_out_active <= 1'b0;
        end else begin
            d_out        <= rd_hit ? rd_data : 8'hFF;
            d_out_active <= rd_hit;
        end
    end
`else
    assign d_out        = 8'hFF;
    assign d_out_active = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: two instances on one bus, checked
// every cycle against a decode-rule model plus literal spot checks.
module tb_io_port_bank;
    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    logic unlock = 1'b0;
    logic [1:0] en_a = 2'b11;
    logic [1:0] en_b = 2'b11;

    logic [15:0] q_a;
    logic [1:0]  stb_a;
    logic        lock_a;
    logic [7:0]  dout_a;
    logic        act_a;
    logic [5:0]  q_b;
    logic [1:0]  stb_b;
    logic        lock_b;
    logic [7:0]  dout_b;
    logic        act_b;

    int vectors = 0;
    int miscompares = 0;
    int stb1_cnt = 0;

    cpu_bus bus ();

    always #5 clk28 = ~clk28;

    io_port_bank #(
        .NPORTS    (2),
        .WIDTH     (8),
        .PORT_ADDR ({16'h7FFD, 16'h00FE}),
        .PORT_MASK ({16'h8002, 16'h0001}),
        .PORT_RST  ({8'h07, 8'h00}),
        .LOCKABLE  (2'b10),
        .LOCK_PORT (1),
        .LOCK_BIT  (5)
    ) dut_a (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .bus          (bus),
        .port_en      (en_a),
        .unlock       (unlock),
        .q            (q_a),
        .wr_stb       (stb_a),
        .locked       (lock_a),
        .d_out        (dout_a),
        .d_out_active (act_a)
    );

    io_port_bank #(
        .NPORTS    (2),
        .WIDTH     (3),
        .PORT_ADDR ({16'h1234, 16'h5678}),
        .PORT_MASK ({16'h0000, 16'h0000}),
        .PORT_RST  (6'b000000),
        .LOCKABLE  (2'b00),
        .LOCK_PORT (0),
        .LOCK_BIT  (5)
    ) dut_b (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .bus          (bus),
        .port_en      (en_b),
        .unlock       (unlock),
        .q            (q_b),
        .wr_stb       (stb_b),
        .locked       (lock_b),
        .d_out        (dout_b),
        .d_out_active (act_b)
    );

    // model state
    logic [7:0] ma_q [2];
    logic [1:0] ma_stb;
    logic       ma_lock;
    logic [7:0] ma_dout;
    logic       ma_act;
    logic [2:0] mb_q [2];
    logic [1:0] mb_stb;
    logic       mb_lock;
    logic [7:0] mb_dout;
    logic       mb_act;
    logic       m_busy;

    logic       first, rd_only;
    logic [1:0] ha, hb, oka, okb;

    task automatic mreset();
        ma_q[0] = 8'h00; ma_q[1] = 8'h07;
        mb_q[0] = 3'd0;  mb_q[1] = 3'd0;
        ma_stb = 2'b00; mb_stb = 2'b00;
        ma_lock = 1'b0; mb_lock = 1'b0;
        ma_dout = 8'hFF; mb_dout = 8'hFF;
        ma_act = 1'b0; mb_act = 1'b0;
        m_busy = 1'b1;
    endtask

    always @(negedge rst_n) mreset();

    always @(posedge clk28) begin
        if (!rst_n) begin
            mreset();
        end else begin
            // port0 answers any even address, port1 needs A15=0 and A1=0
            ha[0] = en_a[0] && !bus.a_reg[0];
            ha[1] = en_a[1] && !bus.a_reg[15] && !bus.a_reg[1];
            hb = en_b;
            first = bus.ioreq && bus.wr && !m_busy;
            rd_only = bus.ioreq && bus.rd && !bus.wr;
`ifdef IO_PORT_READBACK_EN
            ma_act = rd_only && (ha != 2'b00);
            ma_dout = !ma_act ? 8'hFF : (ha[0] ? ma_q[0] : ma_q[1]);
            mb_act = rd_only && (hb != 2'b00);
            mb_dout = !mb_act ? 8'hFF
                    : {5'b11111, (hb[0] ? mb_q[0] : mb_q[1])};
`else
            ma_act = 1'b0; ma_dout = 8'hFF;
            mb_act = 1'b0; mb_dout = 8'hFF;
`endif
            oka[0] = first && ha[0];
            oka[1] = first && ha[1] && (!ma_lock || unlock);
            okb = first ? hb : 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (oka[i]) ma_q[i] = bus.d_reg;
                if (okb[i]) mb_q[i] = bus.d_reg[2:0];
            end
            if (oka[1] && bus.d_reg[5]) ma_lock = 1'b1;
            if (okb[0] && bus.d_reg[5]) mb_lock = 1'b1;
            ma_stb = oka;
            mb_stb = okb;
            m_busy = bus.ioreq && bus.wr;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, want %0h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk28) begin
        chk("a_q", 32'(q_a), 32'({ma_q[1], ma_q[0]}));
        chk("a_stb", 32'(stb_a), 32'(ma_stb));
        chk("a_lock", 32'(lock_a), 32'(ma_lock));
        chk("a_dout", 32'(dout_a), 32'(ma_dout));
        chk("a_act", 32'(act_a), 32'(ma_act));
        chk("b_q", 32'(q_b), 32'({mb_q[1], mb_q[0]}));
        chk("b_stb", 32'(stb_b), 32'(mb_stb));
        chk("b_lock", 32'(lock_b), 32'(mb_lock));
        chk("b_dout", 32'(dout_b), 32'(mb_dout));
        chk("b_act", 32'(act_b), 32'(mb_act));
        if (stb_a[1] === 1'b1) stb1_cnt++;
    end

    task automatic step();
        @(negedge clk28);
        #1;
    endtask

    task automatic bus_idle();
        bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        step();
    endtask

    task automatic wr_cyc(logic [15:0] a, logic [7:0] d, int n);
        bus.a_reg = a; bus.d_reg = d;
        bus.ioreq = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0;
        repeat (n) step();
        bus_idle();
    endtask

    task automatic rd_cyc(logic [15:0] a, int n);
        bus.a_reg = a;
        bus.ioreq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        bus.ioreq = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0;
        bus.a_reg = 16'h00FE; bus.d_reg = 8'h33;
        step(); step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("lit_rst_q_a", 32'(q_a), 32'h0700);
        chk("lit_rst_lock", 32'(lock_a), 32'h0);
        chk("lit_rst_act", 32'(act_a), 32'h0);
        chk("lit_rst_q_b", 32'(q_b), 32'h0);
        bus_idle();

        stb1_cnt = 0;
        wr_cyc(16'h7FFD, 8'h15, 6);
        chk("lit_w15_q_a", 32'(q_a), 32'h1500);
        chk("lit_w15_stb", 32'(stb1_cnt), 32'd1);

        wr_cyc(16'h7FFD, 8'h20, 2);
        chk("lit_lock_set", 32'(lock_a), 32'h1);
        wr_cyc(16'h7FFD, 8'h03, 2);
        chk("lit_locked_w", 32'(q_a), 32'h2000);
        unlock = 1'b1;
        wr_cyc(16'h7FFD, 8'h03, 2);
        unlock = 1'b0;
        chk("lit_unlock_w", 32'(q_a), 32'h0300);
        chk("lit_lock_kept", 32'(lock_a), 32'h1);

        // unlock changes after the commit edge have no effect
        unlock = 1'b1;
        bus.a_reg = 16'h7FFD; bus.d_reg = 8'h11;
        bus.ioreq = 1'b1; bus.wr = 1'b1;
        step();
        unlock = 1'b0;
        repeat (3) step();
        bus_idle();
        bus.a_reg = 16'h7FFD; bus.d_reg = 8'h22;
        bus.ioreq = 1'b1; bus.wr = 1'b1;
        step();
        unlock = 1'b1;
        repeat (3) step();
        bus_idle();
        unlock = 1'b0;
        chk("lit_unlock_mid", 32'(q_a), 32'h1100);

        wr_cyc(16'h00FE, 8'hAA, 3);
        chk("lit_overlap_b", 32'(q_b), 32'(6'b010010));

        rd_cyc(16'h00FE, 2);
`ifdef IO_PORT_READBACK_EN
        chk("lit_rd_a", 32'(dout_a), 32'hAA);
        chk("lit_rd_act", 32'(act_a), 32'h1);
        chk("lit_rd_b", 32'(dout_b), 32'hFA);
`else
        chk("lit_rd_a", 32'(dout_a), 32'hFF);
        chk("lit_rd_act", 32'(act_a), 32'h0);
`endif
        bus_idle();
        chk("lit_rd_drop", 32'(act_a), 32'h0);
        rd_cyc(16'h0001, 3);
        bus_idle();

        bus.a_reg = 16'h00FE; bus.d_reg = 8'h5C;
        bus.ioreq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1;
        repeat (3) step();
        chk("lit_rdwr_act", 32'(act_a), 32'h0);
        bus_idle();
        chk("lit_rdwr_q", 32'(q_a), 32'h115C);

        rd_cyc(16'hFFFF, 2);
        bus_idle();

        en_a = 2'b10;
        wr_cyc(16'h00FE, 8'h77, 2);
        chk("lit_en_off", 32'(q_a), 32'h115C);
        en_a = 2'b11;

        en_b = 2'b10;
        wr_cyc(16'h0000, 8'h05, 2);
        rd_cyc(16'h0000, 2);
`ifdef IO_PORT_READBACK_EN
        chk("lit_w3_rd", 32'(dout_b), 32'hFD);
`endif
        bus_idle();
        en_b = 2'b00;
        rd_cyc(16'h0000, 2);
        chk("lit_b_noen", 32'(act_b), 32'h0);
        bus_idle();
        en_b = 2'b11;

        // reset in the middle of a held write
        bus.a_reg = 16'h7FFD; bus.d_reg = 8'h66;
        bus.ioreq = 1'b1; bus.wr = 1'b1;
        step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("lit_mid_rst_q", 32'(q_a), 32'h0700);
        chk("lit_mid_rst_lk", 32'(lock_a), 32'h0);
        bus_idle();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
